// File: rtl/regfile_hilo_pkg.sv
// Shared register-file constants: bus widths, register count and write-enable levels.
// Imported by the GPR file and the HI/LO pair so both agree on widths.
package regfile_hilo_pkg;

    localparam int REG_NUM_DEF    = 32;
    localparam int REG_DATA_BUS_W = 32;
    localparam int REG_ADDR_BUS_W = 5;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic [REG_DATA_BUS_W-1:0] ZEROWORD = '0;

endpackage

// File: rtl/regfile_hilo_hilo_reg.sv
// HI/LO register pair. Both halves are written together, and a write in
// progress is forwarded to the outputs in the same cycle.
module hilo_reg
    import regfile_hilo_pkg::*;
#(
    parameter int DATA_W = REG_DATA_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hilo_write_en_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (hilo_write_en_i == WRITE_ENABLE) begin
            hi_q <= hi_i;
            lo_q <= lo_i;
        end
    end

    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
        if (rst) begin
            hi_o = '0;
            lo_o = '0;
        end else if (hilo_write_en_i == WRITE_ENABLE) begin
            hi_o = hi_i;
            lo_o = lo_i;
        end
    end

endmodule

// File: rtl/regfile_hilo.sv
// Decode-stage register file: 32 GPRs (r0 reads as zero), two combinational
// read ports with write-through bypass, one write port, plus the HI/LO pair.
module regfile_hilo
    import regfile_hilo_pkg::*;
#(
    parameter int REG_NUM = REG_NUM_DEF,
    parameter int DATA_W  = REG_DATA_BUS_W,
    parameter int ADDR_W  = REG_ADDR_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write_en_i,
    input  logic [ADDR_W-1:0] reg_write_addr_i,
    input  logic [DATA_W-1:0] reg_write_data_i,
    input  logic              reg_read_en_1_i,
    input  logic [ADDR_W-1:0] reg_read_addr_1_i,
    output logic [DATA_W-1:0] reg_data_1_o,
    input  logic              reg_read_en_2_i,
    input  logic [ADDR_W-1:0] reg_read_addr_2_i,
    output logic [DATA_W-1:0] reg_data_2_o,
    input  logic              hilo_write_en_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    // No handshake: every read and write request is served in the cycle it is presented.
    logic [DATA_W-1:0] regs [REG_NUM];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_write_en_i == WRITE_ENABLE && reg_write_addr_i != '0) begin
            regs[reg_write_addr_i] <= reg_write_data_i;
        end
    end

    // Priority: reset, disabled port, r0, same-cycle write-back, stored value.
    always_comb begin
        reg_data_1_o = '0;
        if (rst || reg_read_en_1_i != WRITE_ENABLE || reg_read_addr_1_i == '0) begin
            reg_data_1_o = '0;
        end else if (reg_write_en_i == WRITE_ENABLE && reg_write_addr_i == reg_read_addr_1_i) begin
            reg_data_1_o = reg_write_data_i;
        end else begin
            reg_data_1_o = regs[reg_read_addr_1_i];
        end
    end

    always_comb begin
        reg_data_2_o = '0;
        if (rst || reg_read_en_2_i != WRITE_ENABLE || reg_read_addr_2_i == '0) begin
            reg_data_2_o = '0;
        end else if (reg_write_en_i == WRITE_ENABLE && reg_write_addr_i == reg_read_addr_2_i) begin
            reg_data_2_o = reg_write_data_i;
        end else begin
            reg_data_2_o = regs[reg_read_addr_2_i];
        end
    end

    hilo_reg #(
        .DATA_W(DATA_W)
    ) u_hilo_reg (
        .clk            (clk),
        .rst            (rst),
        .hilo_write_en_i(hilo_write_en_i),
        .hi_i           (hi_i),
        .lo_i           (lo_i),
        .hi_o           (hi_o),
        .lo_o           (lo_o)
    );

endmodule

// File: tb/tb_regfile_hilo.sv
// Bench for regfile_hilo: directed scenarios with constant expectations, then
// randomized traffic checked against an array-based model of the register file.
module tb_regfile_hilo;

    logic        clk;
    logic        rst;
    logic        reg_write_en_i;
    logic [4:0]  reg_write_addr_i;
    logic [31:0] reg_write_data_i;
    logic        reg_read_en_1_i;
    logic [4:0]  reg_read_addr_1_i;
    logic [31:0] reg_data_1_o;
    logic        reg_read_en_2_i;
    logic [4:0]  reg_read_addr_2_i;
    logic [31:0] reg_data_2_o;
    logic        hilo_write_en_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] exp_q [$];

    regfile_hilo dut (
        .clk              (clk),
        .rst              (rst),
        .reg_write_en_i   (reg_write_en_i),
        .reg_write_addr_i (reg_write_addr_i),
        .reg_write_data_i (reg_write_data_i),
        .reg_read_en_1_i  (reg_read_en_1_i),
        .reg_read_addr_1_i(reg_read_addr_1_i),
        .reg_data_1_o     (reg_data_1_o),
        .reg_read_en_2_i  (reg_read_en_2_i),
        .reg_read_addr_2_i(reg_read_addr_2_i),
        .reg_data_2_o     (reg_data_2_o),
        .hilo_write_en_i  (hilo_write_en_i),
        .hi_i             (hi_i),
        .lo_i             (lo_i),
        .hi_o             (hi_o),
        .lo_o             (lo_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change on the falling edge, outputs are sampled 1ns later.
    task automatic drive_idle();
        @(negedge clk);
        rst = 1'b0;
        reg_write_en_i = 1'b0; reg_write_addr_i = '0; reg_write_data_i = '0;
        reg_read_en_1_i = 1'b0; reg_read_addr_1_i = '0;
        reg_read_en_2_i = 1'b0; reg_read_addr_2_i = '0;
        hilo_write_en_i = 1'b0; hi_i = '0; lo_i = '0;
        #1;
    endtask

    task automatic drive_write(input logic [4:0] a, input logic [31:0] d);
        reg_write_en_i = 1'b1; reg_write_addr_i = a; reg_write_data_i = d;
        #1;
    endtask

    task automatic drive_read(input logic e1, input logic [4:0] a1,
                              input logic e2, input logic [4:0] a2);
        reg_read_en_1_i = e1; reg_read_addr_1_i = a1;
        reg_read_en_2_i = e2; reg_read_addr_2_i = a2;
        #1;
    endtask

    task automatic drive_hilo(input logic [31:0] h, input logic [31:0] l);
        hilo_write_en_i = 1'b1; hi_i = h; lo_i = l;
        #1;
    endtask

    // Reference model: architectural state updated at each rising edge.
    task automatic commit();
        @(posedge clk);
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_hi = '0;
            m_lo = '0;
        end else begin
            if (reg_write_en_i && reg_write_addr_i != 5'd0) m_regs[reg_write_addr_i] = reg_write_data_i;
            if (hilo_write_en_i) begin
                m_hi = hi_i;
                m_lo = lo_i;
            end
        end
    endtask

    function automatic logic [31:0] model_read(input logic en, input logic [4:0] a);
        if (rst || !en || a == 5'd0) return 32'h0;
        if (reg_write_en_i && reg_write_addr_i == a) return reg_write_data_i;
        return m_regs[a];
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_write(5'd4, 32'h1111_2222);
        drive_read(1'b1, 5'd4, 1'b1, 5'd4);
        drive_hilo(32'h3, 32'h4);
        n_checks++;
        if ({reg_data_1_o, reg_data_2_o, hi_o, lo_o} !== 128'h0)
            $display("FAIL reset_outputs: got %h %h %h %h, expected all 0", reg_data_1_o, reg_data_2_o, hi_o, lo_o);
        else n_pass++;
        commit();
        drive_idle();
        drive_write(5'd5, 32'hDEAD_BEEF);
        commit();
        drive_idle();
        rst = 1'b1;
        commit();
        drive_idle();
        drive_read(1'b1, 5'd5, 1'b0, 5'd0);
        n_checks++;
        if (reg_data_1_o !== 32'h0) $display("FAIL reset_clears_r5: got %h, expected 00000000", reg_data_1_o);
        else n_pass++;
        n_checks++;
        if (hi_o !== 32'h0 || lo_o !== 32'h0) $display("FAIL reset_hilo: got %h/%h, expected 0/0", hi_o, lo_o);
        else n_pass++;
        commit();
    endtask

    task automatic test_r0();
        drive_idle();
        drive_write(5'd0, 32'hFFFF_FFFF);
        drive_read(1'b1, 5'd0, 1'b1, 5'd0);
        n_checks++;
        if (reg_data_1_o !== 32'h0 || reg_data_2_o !== 32'h0)
            $display("FAIL r0_no_bypass: got %h/%h, expected 0/0", reg_data_1_o, reg_data_2_o);
        else n_pass++;
        commit();
        drive_idle();
        drive_read(1'b1, 5'd0, 1'b1, 5'd0);
        n_checks++;
        if (reg_data_1_o !== 32'h0 || reg_data_2_o !== 32'h0)
            $display("FAIL r0_immutable: got %h/%h, expected 0/0", reg_data_1_o, reg_data_2_o);
        else n_pass++;
        commit();
    endtask

    task automatic test_bypass();
        drive_idle();
        drive_write(5'd7, 32'h1234_5678);
        drive_read(1'b1, 5'd7, 1'b0, 5'd0);
        n_checks++;
        if (reg_data_1_o !== 32'h1234_5678) $display("FAIL bypass_same_cycle: got %h, expected 12345678", reg_data_1_o);
        else n_pass++;
        commit();
        drive_idle();
        drive_read(1'b1, 5'd7, 1'b0, 5'd0);
        n_checks++;
        if (reg_data_1_o !== 32'h1234_5678) $display("FAIL bypass_stored: got %h, expected 12345678", reg_data_1_o);
        else n_pass++;
        commit();
    endtask

    task automatic test_read_enable();
        drive_idle();
        drive_write(5'd3, 32'hA5A5_A5A5);
        commit();
        drive_idle();
        drive_read(1'b0, 5'd0, 1'b0, 5'd3);
        n_checks++;
        if (reg_data_2_o !== 32'h0) $display("FAIL read_en_low: got %h, expected 00000000", reg_data_2_o);
        else n_pass++;
        drive_read(1'b0, 5'd0, 1'b1, 5'd3);
        n_checks++;
        if (reg_data_2_o !== 32'hA5A5_A5A5) $display("FAIL read_en_high: got %h, expected a5a5a5a5", reg_data_2_o);
        else n_pass++;
        commit();
    endtask

    task automatic test_hilo();
        drive_idle();
        drive_hilo(32'h1, 32'h2);
        n_checks++;
        if (hi_o !== 32'h1 || lo_o !== 32'h2) $display("FAIL hilo_bypass: got %h/%h, expected 1/2", hi_o, lo_o);
        else n_pass++;
        commit();
        drive_idle();
        n_checks++;
        if (hi_o !== 32'h1 || lo_o !== 32'h2) $display("FAIL hilo_stored: got %h/%h, expected 1/2", hi_o, lo_o);
        else n_pass++;
        rst = 1'b1;
        drive_hilo(32'h7, 32'h8);
        n_checks++;
        if (hi_o !== 32'h0 || lo_o !== 32'h0) $display("FAIL hilo_in_reset: got %h/%h, expected 0/0", hi_o, lo_o);
        else n_pass++;
        commit();
        drive_idle();
        n_checks++;
        if (hi_o !== 32'h0 || lo_o !== 32'h0) $display("FAIL hilo_reset_write_dropped: got %h/%h, expected 0/0", hi_o, lo_o);
        else n_pass++;
        commit();
    endtask

    task automatic test_dual_concurrent();
        drive_idle();
        drive_write(5'd9, 32'h55);
        drive_read(1'b1, 5'd9, 1'b1, 5'd9);
        drive_hilo(32'hAA, 32'hBB);
        n_checks++;
        if (reg_data_1_o !== 32'h55 || reg_data_2_o !== 32'h55)
            $display("FAIL dual_bypass: got %h/%h, expected 55/55", reg_data_1_o, reg_data_2_o);
        else n_pass++;
        commit();
        drive_idle();
        drive_read(1'b1, 5'd9, 1'b1, 5'd9);
        n_checks++;
        if (reg_data_1_o !== 32'h55 || reg_data_2_o !== 32'h55)
            $display("FAIL dual_stored: got %h/%h, expected 55/55", reg_data_1_o, reg_data_2_o);
        else n_pass++;
        n_checks++;
        if (hi_o !== 32'hAA || lo_o !== 32'hBB) $display("FAIL concurrent_hilo: got %h/%h, expected aa/bb", hi_o, lo_o);
        else n_pass++;
        commit();
    endtask

    task automatic test_random();
        logic [31:0] exp;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 40) == 0);
            reg_write_en_i    = $urandom_range(0, 1);
            reg_write_addr_i  = 5'($urandom_range(0, 31) < 24 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            reg_write_data_i  = $urandom;
            reg_read_en_1_i   = ($urandom_range(0, 7) != 0);
            reg_read_addr_1_i = 5'($urandom_range(0, 7));
            reg_read_en_2_i   = ($urandom_range(0, 7) != 0);
            reg_read_addr_2_i = 5'($urandom_range(0, 1) ? reg_write_addr_i : 5'($urandom_range(0, 31)));
            hilo_write_en_i   = ($urandom_range(0, 3) == 0);
            hi_i = $urandom;
            lo_i = $urandom;
            #1;
            exp_q.push_back(model_read(reg_read_en_1_i, reg_read_addr_1_i));
            exp_q.push_back(model_read(reg_read_en_2_i, reg_read_addr_2_i));
            exp_q.push_back(rst ? 32'h0 : (hilo_write_en_i ? hi_i : m_hi));
            exp_q.push_back(rst ? 32'h0 : (hilo_write_en_i ? lo_i : m_lo));
            exp = exp_q.pop_front();
            n_checks++;
            if (reg_data_1_o !== exp) $display("FAIL rand_port1 n=%0d: got %h, expected %h", n, reg_data_1_o, exp);
            else n_pass++;
            exp = exp_q.pop_front();
            n_checks++;
            if (reg_data_2_o !== exp) $display("FAIL rand_port2 n=%0d: got %h, expected %h", n, reg_data_2_o, exp);
            else n_pass++;
            exp = exp_q.pop_front();
            n_checks++;
            if (hi_o !== exp) $display("FAIL rand_hi n=%0d: got %h, expected %h", n, hi_o, exp);
            else n_pass++;
            exp = exp_q.pop_front();
            n_checks++;
            if (lo_o !== exp) $display("FAIL rand_lo n=%0d: got %h, expected %h", n, lo_o, exp);
            else n_pass++;
            commit();
        end
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = '0;
        m_hi = '0;
        m_lo = '0;
        rst = 1'b1;
        reg_write_en_i = 1'b0; reg_write_addr_i = '0; reg_write_data_i = '0;
        reg_read_en_1_i = 1'b0; reg_read_addr_1_i = '0;
        reg_read_en_2_i = 1'b0; reg_read_addr_2_i = '0;
        hilo_write_en_i = 1'b0; hi_i = '0; lo_i = '0;
        test_reset();
        test_r0();
        test_bypass();
        test_read_enable();
        test_hilo();
        test_dual_concurrent();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
